// File: rtl/tile_pkg.sv
// Shared encodings, colours and board geometry for the tile renderer.
package tile_pkg;

    localparam int BOARD_DIM = 4;
    localparam int DIM_BITS  = $clog2(BOARD_DIM);
    localparam int NUM_TILES = BOARD_DIM * BOARD_DIM;

    typedef logic [2*DIM_BITS-1:0] tile_idx_t;

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        REVEALED = 2'd1,
        MATCHED  = 2'd2,
        EMPTY    = 2'd3
    } tile_state_e;

    typedef struct packed {
        tile_state_e state;
        logic [2:0]  sym;
    } tile_entry_t;

    typedef logic [23:0] rgb_t;

    localparam rgb_t BG     = 24'h101010;
    localparam rgb_t BACK   = 24'h2040A0;
    localparam rgb_t WHITE  = 24'hFFFFFF;
    localparam rgb_t CURSOR = 24'hFFFF00;

    localparam rgb_t PALETTE [8] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF8000,
        24'h00FFFF, 24'hFF00FF, 24'h8000FF, 24'h80FF80
    };

endpackage

// File: rtl/tile_board_regs.sv
// 16-entry board state file: one write/clear port, one combinational read port.
module tile_board_regs
    import tile_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        we_i,
    input  tile_idx_t   waddr_i,
    input  tile_entry_t wdata_i,
    input  tile_idx_t   raddr_i,
    output tile_entry_t rdata_o
);

    tile_entry_t mem_q [NUM_TILES];

    // Clear wins over a same-cycle write so a board reset is never half-applied.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < NUM_TILES; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-write value during the cycle of a write.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tile_pixel_renderer.sv
// Two-stage pixel colour pipeline for the 4x4 tile board plus frame tick.
module tile_pixel_renderer
    import tile_pkg::*;
#(
    parameter int BOARD_X0   = 192,
    parameter int BOARD_Y0   = 112,
    parameter int TILE_SHIFT = 6,
    parameter int BORDER_PX  = 2
) (
    input  logic       pixelClk,
    input  logic       reset,
    input  logic [9:0] xCoord,
    input  logic [9:0] yCoord,
    input  logic       visible,
    input  logic [3:0] cursor_idx,
    input  logic       tile_we,
    input  logic [3:0] tile_waddr,
    input  logic [4:0] tile_wdata,
    input  logic       clear_board,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_tick
);

    localparam int TILE_PX = 1 << TILE_SHIFT;
    localparam int SPAN    = BOARD_DIM << TILE_SHIFT;

    typedef logic [TILE_SHIFT+DIM_BITS-1:0] off_t;
    typedef logic [TILE_SHIFT-1:0]          loc_t;

    localparam logic [10:0] X_LO = 11'(BOARD_X0);
    localparam logic [10:0] X_HI = 11'(BOARD_X0 + SPAN);
    localparam logic [10:0] Y_LO = 11'(BOARD_Y0);
    localparam logic [10:0] Y_HI = 11'(BOARD_Y0 + SPAN);
    localparam loc_t        B_LO = loc_t'(BORDER_PX);
    localparam loc_t        B_HI = loc_t'(TILE_PX - BORDER_PX);

    // Stage-1 decode signals
    logic [10:0]         x_ext, y_ext;
    off_t                dx, dy;
    loc_t                lx, ly;
    logic [DIM_BITS-1:0] col, row;
    logic                s1_board_d, s1_board_q;
    logic                s1_border_d, s1_border_q;
    tile_idx_t           s1_idx_d, s1_idx_q;

    // Stage-2 and frame signals
    tile_entry_t         rd_entry;
    rgb_t                rgb_d, rgb_q;
    logic                tick_d, tick_q;
    logic [5:0]          flash_cnt_q;

    // Board-relative geometry; only the low bits of the offsets matter once in-board.
    always_comb begin
        x_ext       = {1'b0, xCoord};
        y_ext       = {1'b0, yCoord};
        dx          = off_t'(xCoord) - off_t'(BOARD_X0);
        dy          = off_t'(yCoord) - off_t'(BOARD_Y0);
        lx          = dx[TILE_SHIFT-1:0];
        ly          = dy[TILE_SHIFT-1:0];
        col         = dx[TILE_SHIFT +: DIM_BITS];
        row         = dy[TILE_SHIFT +: DIM_BITS];
        s1_board_d  = (x_ext >= X_LO) && (x_ext < X_HI) &&
                      (y_ext >= Y_LO) && (y_ext < Y_HI);
        s1_idx_d    = {row, col};
        s1_border_d = (lx < B_LO) || (lx >= B_HI) || (ly < B_LO) || (ly >= B_HI);
    end

    // Stage 1: register the decoded position; reset parks it off-board.
    always_ff @(posedge pixelClk) begin
        if (reset) begin
            s1_board_q  <= 1'b0;
            s1_border_q <= 1'b0;
            s1_idx_q    <= '0;
        end else begin
            s1_board_q  <= s1_board_d;
            s1_border_q <= s1_border_d;
            s1_idx_q    <= s1_idx_d;
        end
    end

    tile_board_regs u_regs (
        .clk_i   (pixelClk),
        .rst_i   (reset),
        .clear_i (clear_board),
        .we_i    (tile_we),
        .waddr_i (tile_waddr),
        .wdata_i (tile_entry_t'(tile_wdata)),
        .raddr_i (s1_idx_q),
        .rdata_o (rd_entry)
    );

    // Colour selection from the tile entry, border ring and flash phase.
    always_comb begin
        rgb_d = BG;
        if (s1_board_q) begin
            if (s1_border_q) begin
                rgb_d = (s1_idx_q == cursor_idx) ? CURSOR : BG;
            end else begin
                case (rd_entry.state)
                    HIDDEN:   rgb_d = BACK;
                    REVEALED: rgb_d = PALETTE[rd_entry.sym];
                    MATCHED:  rgb_d = flash_cnt_q[4] ? WHITE : PALETTE[rd_entry.sym];
                    default:  rgb_d = BG;
                endcase
            end
        end
    end

    // Stage 2: register the chosen colour.
    always_ff @(posedge pixelClk) begin
        if (reset) rgb_q <= BG;
        else       rgb_q <= rgb_d;
    end

    // y==480 at x==0 only happens once per frame since y never exceeds 511.
    assign tick_d = (xCoord == 10'd0) && (yCoord == 10'd480);

    // Frame tick pulse and the flash counter it advances.
    always_ff @(posedge pixelClk) begin
        if (reset) begin
            tick_q      <= 1'b0;
            flash_cnt_q <= '0;
        end else begin
            tick_q <= tick_d;
            if (tick_q) flash_cnt_q <= flash_cnt_q + 6'd1;
        end
    end

    assign frame_tick = tick_q;

    // Blanking must come from visible: yCoord wraps during vblank.
    assign {VGA_R, VGA_G, VGA_B} = visible ? rgb_q : 24'h0;

endmodule

// File: tb/tb_tile_pixel_renderer.sv
// Randomised and directed checks of the tile renderer against a pixel-level model.
module tb_tile_pixel_renderer;
    import tile_pkg::*;

    logic       pixelClk, reset;
    logic [9:0] xCoord, yCoord;
    logic       visible;
    logic [3:0] cursor_idx;
    logic       tile_we;
    logic [3:0] tile_waddr;
    logic [4:0] tile_wdata;
    logic       clear_board;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       frame_tick;

    tile_pixel_renderer dut (
        .pixelClk   (pixelClk),
        .reset      (reset),
        .xCoord     (xCoord),
        .yCoord     (yCoord),
        .visible    (visible),
        .cursor_idx (cursor_idx),
        .tile_we    (tile_we),
        .tile_waddr (tile_waddr),
        .tile_wdata (tile_wdata),
        .clear_board(clear_board),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .frame_tick (frame_tick)
    );

    initial pixelClk = 1'b0;
    always #5 pixelClk = ~pixelClk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_tiles [16];
    int   m_flash;
    bit   m_tick;
    rgb_t m_rgb;
    bit   pv_valid;
    int   pv_x, pv_y;
    bit   chk_en = 0;
    int   tick_seen = 0;

    // Colour of a screen pixel from the board rules, using the current model state.
    function automatic rgb_t colour_of(input int x, input int y, input int cur);
        int dx, dy, lx, ly, idx, st, sym;
        dx = x - 192;
        dy = y - 112;
        if (dx < 0 || dx >= 256 || dy < 0 || dy >= 256) return BG;
        lx  = dx % 64;
        ly  = dy % 64;
        idx = (dy / 64) * 4 + dx / 64;
        if (lx < 2 || lx >= 62 || ly < 2 || ly >= 62) return (idx == cur) ? CURSOR : BG;
        st  = m_tiles[idx] / 8;
        sym = m_tiles[idx] % 8;
        case (st)
            0:       return BACK;
            1:       return PALETTE[sym];
            2:       return ((m_flash / 16) % 2 == 1) ? WHITE : PALETTE[sym];
            default: return BG;
        endcase
    endfunction

    // Compare process: every cycle after the first reset, then advance the model.
    always @(negedge pixelClk) begin
        rgb_t got, nxt;
        got = {VGA_R, VGA_G, VGA_B};
        if (chk_en) begin
            check("pixel_rgb", got, visible ? m_rgb : 24'h0);
            check("frame_tick", {23'h0, frame_tick}, {23'h0, m_tick});
            if (frame_tick) tick_seen++;
        end
        nxt = (reset || !pv_valid) ? BG : colour_of(pv_x, pv_y, int'(cursor_idx));
        pv_valid = !reset;
        pv_x     = int'(xCoord);
        pv_y     = int'(yCoord);
        if (reset) begin
            for (int i = 0; i < 16; i++) m_tiles[i] = 0;
            m_flash = 0;
            m_tick  = 0;
            chk_en  = 1;
        end else begin
            if (clear_board) for (int i = 0; i < 16; i++) m_tiles[i] = 0;
            else if (tile_we) m_tiles[tile_waddr] = int'(tile_wdata);
            if (m_tick) m_flash = (m_flash + 1) % 64;
            m_tick = (xCoord == 10'd0) && (yCoord == 10'd480);
        end
        m_rgb = nxt;
    end

    // ---------------- stimulus ----------------
    bit v1 = 0, v2 = 0;

    // One pixel-clock cycle of inputs; visible trails the coordinates by two cycles.
    task automatic step(input logic [9:0] x, input logic [9:0] y, input bit v,
                        input bit we = 1'b0, input logic [3:0] wa = 4'd0,
                        input logic [4:0] wd = 5'd0, input bit clr = 1'b0,
                        input bit rst = 1'b0);
        @(posedge pixelClk);
        #1;
        xCoord      = x;
        yCoord      = y;
        visible     = v2;
        v2          = v1;
        v1          = v;
        tile_we     = we;
        tile_waddr  = wa;
        tile_wdata  = wd;
        clear_board = clr;
        reset       = rst;
    endtask

    task automatic probe(input string name, input int x, input int y, input rgb_t want);
        step(10'(x), 10'(y), 1'b1);
        step(10'd0, 10'd0, 1'b0);
        step(10'd0, 10'd0, 1'b0);
        @(negedge pixelClk);
        check(name, {VGA_R, VGA_G, VGA_B}, want);
    endtask

    task automatic do_reset();
        repeat (3) step(10'd300, 10'd200, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 1'b1);
    endtask

    int lines [15] = '{0, 111, 112, 113, 114, 150, 174, 175, 176, 177, 240, 367, 368, 400, 479};
    int xs [6]     = '{0, 1, 320, 639, 700, 799};

    initial begin
        int t0;
        xCoord = 0; yCoord = 0; visible = 0; cursor_idx = 4'd15;
        tile_we = 0; tile_waddr = 0; tile_wdata = 0; clear_board = 0; reset = 1;

        // Reset: visible pixels queued during reset still read BG afterwards.
        do_reset();
        step(10'd0, 10'd0, 1'b0);
        @(negedge pixelClk);
        check("reset_rgb_bg", {VGA_R, VGA_G, VGA_B}, 24'h101010);
        check("reset_tick", {23'h0, frame_tick}, 24'h0);
        check("model_pin_back", colour_of(300, 300, 15), 24'h2040A0);

        // Empty board over boundary-rich lines.
        foreach (lines[i])
            for (int x = 180; x <= 460; x++)
                step(10'(x), 10'(lines[i]), (x < 640) && (lines[i] < 480));
        probe("empty_interior", 230, 130, 24'h2040A0);
        probe("empty_border", 193, 200, 24'h101010);
        probe("outside_board", 100, 100, 24'h101010);

        // Revealed tile 5, symbol 3.
        step(10'd0, 10'd0, 1'b0, 1'b1, 4'd5, 5'b01_011);
        step(10'd0, 10'd0, 1'b0);
        check("model_pin_pal3", colour_of(260, 180, 15), 24'hFF8000);
        probe("tile5_revealed", 260, 180, 24'hFF8000);

        // Cursor on tile 5.
        cursor_idx = 4'd5;
        probe("cursor_border", 256, 180, 24'hFFFF00);
        probe("tile0_border_bg", 192, 112, 24'h101010);
        cursor_idx = 4'd15;

        // Full frame of line starts: one tick per 525 lines, none in the wrapped tail.
        t0 = tick_seen;
        for (int ln = 0; ln < 512; ln++)
            foreach (xs[k]) step(10'(xs[k]), 10'(ln), (xs[k] < 640) && (ln < 480));
        step(10'd5, 10'd0, 1'b0);
        step(10'd5, 10'd0, 1'b0);
        check("ticks_per_frame", 24'(tick_seen - t0), 24'd1);
        t0 = tick_seen;
        for (int ln = 512; ln < 525; ln++)
            foreach (xs[k]) step(10'(xs[k]), 10'(ln % 512), 1'b0);
        step(10'd5, 10'd0, 1'b0);
        step(10'd5, 10'd0, 1'b0);
        check("vblank_wrap_ticks", 24'(tick_seen - t0), 24'd0);

        // Matched tile flashing: 16 ticks per phase.
        do_reset();
        step(10'd0, 10'd0, 1'b0, 1'b1, 4'd0, 5'b10_010);
        probe("flash_k0", 200, 120, 24'h0000FF);
        for (int k = 1; k <= 32; k++) begin
            step(10'd0, 10'd480, 1'b0);
            probe($sformatf("flash_k%0d", k), 200, 120,
                  ((k / 16) % 2 == 1) ? 24'hFFFFFF : 24'h0000FF);
        end

        // Clear beats a same-cycle write.
        step(10'd0, 10'd0, 1'b0, 1'b1, 4'd3, 5'b01_001);
        step(10'd0, 10'd0, 1'b0, 1'b1, 4'd9, 5'b11_000);
        step(10'd0, 10'd0, 1'b0, 1'b1, 4'd3, 5'b01_111, 1'b1);
        for (int t = 0; t < 16; t++)
            probe($sformatf("clear_tile%0d", t), 192 + (t % 4) * 64 + 30,
                  112 + (t / 4) * 64 + 30, 24'h2040A0);

        // Random traffic against the model.
        for (int n = 0; n < 6000; n++) begin
            logic [9:0] x, y;
            if ($urandom_range(0, 40) == 0) begin
                x = 10'd0; y = 10'd480;
            end else begin
                x = 10'($urandom_range(0, 799));
                y = 10'($urandom_range(0, 511));
            end
            if ($urandom_range(0, 50) == 0) cursor_idx = 4'($urandom_range(0, 15));
            step(x, y, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                 5'($urandom_range(0, 31)), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 499) == 0));
        end
        step(10'd0, 10'd0, 1'b0);
        step(10'd0, 10'd0, 1'b0);
        @(negedge pixelClk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
